// File: rtl/seg_pkg.sv
// Shared types, segment constants and the digit-to-segment table for the
// binary-to-seven-segment front end.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ENCODE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_DASH  = 7'h40;
   localparam int unsigned MAX_DISP = 99;

   // Patterns are {g,f,e,d,c,b,a}, active-high. Non-decimal codes show a dash.
   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'h3F;
         4'd1:    seg = 7'h06;
         4'd2:    seg = 7'h5B;
         4'd3:    seg = 7'h4F;
         4'd4:    seg = 7'h66;
         4'd5:    seg = 7'h6D;
         4'd6:    seg = 7'h7D;
         4'd7:    seg = 7'h07;
         4'd8:    seg = 7'h7F;
         4'd9:    seg = 7'h6F;
         default: seg = SEG_DASH;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Combinational BCD digit to seven-segment pattern decoder.
module seg_digit_decode
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = digit_to_seg(digit);

endmodule

// File: rtl/bin2seg_encoder.sv
// Binary to two-digit seven-segment encoder: accepts a value over valid/ready,
// converts it with a sequential double-dabble loop and registers both patterns.
module bin2seg_encoder
   import seg_pkg::*;
#(
   parameter int IN_W     = 7,
   parameter bit BLANK_LZ = 1'b1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [IN_W-1:0] in_value,
   output logic [13:0]     both7seg,
   output logic            out_valid,
   output logic            ovf
);

   localparam int CNT_W = $clog2(IN_W + 1);

   state_t            state_reg, state_next;
   logic [IN_W-1:0]   bin_reg, bin_next;
   logic [7:0]        bcd_reg, bcd_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              over_reg, over_next;
   logic [13:0]       seg_reg, seg_next;
   logic              ovf_reg, ovf_next;
   logic              out_valid_reg, out_valid_next;

   logic [7:0]        bcd_adj;
   logic [13:0]       dig_seg;
   logic [6:0]        tens_seg, units_seg;

   // Per-nibble add-3 correction and decode; index 1 is tens, 0 is units.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_digit
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
         seg_digit_decode u_dec (
            .digit (bcd_reg[gi*4 +: 4]),
            .seg   (dig_seg[gi*7 +: 7])
         );
      end
   endgenerate

   always_comb begin
      tens_seg  = dig_seg[13:7];
      units_seg = dig_seg[6:0];
      if (over_reg) begin
         tens_seg  = SEG_DASH;
         units_seg = SEG_DASH;
      end else if (BLANK_LZ && bcd_reg[7:4] == 4'd0) begin
         tens_seg  = SEG_BLANK;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bin_next       = bin_reg;
      bcd_next       = bcd_reg;
      cnt_next       = cnt_reg;
      over_next      = over_reg;
      seg_next       = seg_reg;
      ovf_next       = ovf_reg;
      out_valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               bin_next   = in_value;
               bcd_next   = 8'd0;
               cnt_next   = CNT_W'(IN_W);
               over_next  = (32'(in_value) > MAX_DISP);
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            // Bits shifted out of the top of bcd only occur when over is set.
            {bcd_next, bin_next} = {bcd_adj, bin_reg} << 1;
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               state_next = ENCODE;
            end
         end
         ENCODE: begin
            seg_next       = {tens_seg, units_seg};
            ovf_next       = over_reg;
            out_valid_next = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         bin_reg       <= '0;
         bcd_reg       <= '0;
         cnt_reg       <= '0;
         over_reg      <= 1'b0;
         seg_reg       <= '0;
         ovf_reg       <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bin_reg       <= bin_next;
         bcd_reg       <= bcd_next;
         cnt_reg       <= cnt_next;
         over_reg      <= over_next;
         seg_reg       <= seg_next;
         ovf_reg       <= ovf_next;
         out_valid_reg <= out_valid_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign both7seg  = seg_reg;
   assign ovf       = ovf_reg;
   assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_bin2seg_encoder.sv
// Self-checking bench: two encoders (leading-zero blanking on and off) share
// the same stimulus and are compared against a decimal-arithmetic model.
module tb_bin2seg_encoder;

   localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [6:0]  in_value = '0;
   logic        in_ready, out_valid, ovf;
   logic [13:0] both7seg;
   logic        in_ready_nb, out_valid_nb, ovf_nb;
   logic [13:0] both7seg_nb;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bin2seg_encoder #(.IN_W(7), .BLANK_LZ(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_value(in_value), .both7seg(both7seg), .out_valid(out_valid), .ovf(ovf)
   );

   bin2seg_encoder #(.IN_W(7), .BLANK_LZ(1'b0)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nb),
      .in_value(in_value), .both7seg(both7seg_nb), .out_valid(out_valid_nb), .ovf(ovf_nb)
   );

   // Reference: decimal digits by division, dash on both digits above 99.
   function automatic logic [13:0] ref_seg(input int v, input bit blank);
      int t, u;
      logic [6:0] hi;
      if (v > 99) return {7'h40, 7'h40};
      t  = v / 10;
      u  = v % 10;
      hi = (blank && t == 0) ? 7'h00 : SEG_TAB[t];
      return {hi, SEG_TAB[u]};
   endfunction

   // Presents one value for a single cycle, then counts edges until out_valid.
   task automatic do_xfer(input int v, output int lat);
      in_value = 7'(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (both7seg !== 14'h0000 || out_valid !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: seg=%h ov=%b ovf=%b required seg=0000 ov=0 ovf=0",
                  both7seg, out_valid, ovf);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || in_ready_nb !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b/%b required 1", in_ready, in_ready_nb);
      end
      $display("test_reset: seg=%h ovf=%b in_ready=%b", both7seg, ovf, in_ready);
   endtask

   task automatic test_latency;
      int lat;
      int low_cnt;
      in_value = 7'd42;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      low_cnt = 0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         if (in_ready === 1'b0) low_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL latency_42: edges=%0d required 8", lat);
      end
      checks++;
      if (low_cnt != 8 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_low_42: low_cycles=%0d ready_at_result=%b required 8 and 1",
                  low_cnt, in_ready);
      end
      checks++;
      if (both7seg !== 14'h335B || ovf !== 1'b0) begin
         errors++;
         $display("FAIL value_42: seg=%h ovf=%b required 335B 0", both7seg, ovf);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || both7seg !== 14'h335B) begin
         errors++;
         $display("FAIL pulse_42: out_valid=%b seg=%h required 0 335B", out_valid, both7seg);
      end
      $display("test_latency: value=42 lat=%0d seg=%h", lat, both7seg);
   endtask

   task automatic test_values;
      int vals   [6] = '{7, 0, 99, 127, 5, 70};
      logic [13:0] exp_b [6] = '{14'h0007, 14'h003F, 14'h37EF, 14'h2040, 14'h006D, 14'h03BF};
      logic [13:0] exp_n [6] = '{14'h1F87, 14'h1FBF, 14'h37EF, 14'h2040, 14'h1FED, 14'h03BF};
      logic        exp_o [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         do_xfer(vals[i], lat);
         checks++;
         if (lat != 8 || out_valid_nb !== 1'b1) begin
            errors++;
            $display("FAIL lat_%0d: edges=%0d nb_valid=%b required 8 1", vals[i], lat, out_valid_nb);
         end
         checks++;
         if (both7seg !== exp_b[i] || ovf !== exp_o[i]) begin
            errors++;
            $display("FAIL blank_%0d: seg=%h ovf=%b required %h %b",
                     vals[i], both7seg, ovf, exp_b[i], exp_o[i]);
         end
         checks++;
         if (both7seg_nb !== exp_n[i] || ovf_nb !== exp_o[i]) begin
            errors++;
            $display("FAIL noblank_%0d: seg=%h ovf=%b required %h %b",
                     vals[i], both7seg_nb, ovf_nb, exp_n[i], exp_o[i]);
         end
         $display("test_values: value=%0d seg=%h seg_nb=%h ovf=%b", vals[i], both7seg, both7seg_nb, ovf);
      end
   endtask

   task automatic test_back_to_back;
      int pulses = 0;
      int t1 = -1, t2 = -1;
      logic [13:0] s1 = '0, s2 = '0;
      logic rdy8 = 1'b0;
      in_value = 7'd12;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_value = 7'd34;
      for (int c = 1; c <= 25; c++) begin
         @(posedge clk); #1;
         if (c == 8) rdy8 = in_ready;
         if (c == 9) in_valid = 1'b0;
         if (out_valid === 1'b1) begin
            pulses++;
            if (pulses == 1) begin t1 = c; s1 = both7seg; end
            if (pulses == 2) begin t2 = c; s2 = both7seg; end
         end
      end
      checks++;
      if (pulses != 2 || rdy8 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_pulses: pulses=%0d ready_at_8=%b required 2 1", pulses, rdy8);
      end
      checks++;
      if (t1 != 8 || s1 !== 14'h035B) begin
         errors++;
         $display("FAIL b2b_first: at=%0d seg=%h required 8 035B", t1, s1);
      end
      checks++;
      if (t2 != 17 || s2 !== 14'h27E6) begin
         errors++;
         $display("FAIL b2b_second: at=%0d seg=%h required 17 27E6", t2, s2);
      end
      $display("test_back_to_back: pulses=%0d t1=%0d seg1=%h t2=%0d seg2=%h", pulses, t1, s1, t2, s2);
   endtask

   task automatic test_reset_mid;
      int lat;
      int pulses = 0;
      do_xfer(127, lat);
      @(posedge clk); #1;
      in_value = 7'd55;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (both7seg !== 14'h0000 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_state: seg=%h ovf=%b ov=%b rdy=%b required 0000 0 0 1",
                  both7seg, ovf, out_valid, in_ready);
      end
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || both7seg !== 14'h0000) begin
         errors++;
         $display("FAIL abort_quiet: pulses=%0d seg=%h required 0 0000", pulses, both7seg);
      end
      do_xfer(55, lat);
      checks++;
      if (lat != 8 || both7seg !== 14'h36ED || ovf !== 1'b0) begin
         errors++;
         $display("FAIL after_abort_55: lat=%0d seg=%h ovf=%b required 8 36ED 0", lat, both7seg, ovf);
      end
      $display("test_reset_mid: after abort seg=%h lat=%0d", both7seg, lat);
   endtask

   task automatic test_random;
      int v, lat;
      logic [13:0] eb, en;
      logic eo;
      for (int i = 0; i < 30; i++) begin
         repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         v  = int'($urandom_range(0, 127));
         eb = ref_seg(v, 1'b1);
         en = ref_seg(v, 1'b0);
         eo = (v > 99);
         do_xfer(v, lat);
         checks++;
         if (lat != 8 || both7seg !== eb || ovf !== eo || both7seg_nb !== en || ovf_nb !== eo) begin
            errors++;
            $display("FAIL rand_%0d: lat=%0d seg=%h/%h ovf=%b/%b required 8 %h/%h %b",
                     v, lat, both7seg, both7seg_nb, ovf, ovf_nb, eb, en, eo);
         end
         $display("test_random: value=%0d seg=%h seg_nb=%h ovf=%b", v, both7seg, both7seg_nb, ovf);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_values();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
